// File: rtl/vdc_pkg.sv
// vdc_pkg: shared register indices, port selects, FSM states and increment decode for the VDC CPU port
package vdc_pkg;
    localparam logic [4:0] REG_MAWR = 5'h00;
    localparam logic [4:0] REG_MARR = 5'h01;
    localparam logic [4:0] REG_VRW  = 5'h02;
    localparam logic [4:0] REG_CR   = 5'h05;
    localparam logic [1:0] PORT_AR  = 2'd0;
    localparam logic [1:0] PORT_LSB = 2'd2;
    localparam logic [1:0] PORT_MSB = 2'd3;
    typedef enum logic [1:0] {ST_IDLE, ST_WREQ, ST_RREQ} st_e;
    function automatic logic [15:0] inc_of(input logic [1:0] cr);
        return (cr == 2'b00) ? 16'd1 : (cr == 2'b01) ? 16'd32 : (cr == 2'b10) ? 16'd64 : 16'd128;
    endfunction
endpackage

// File: rtl/vdc_cpu_port_if.sv
// vdc_cpu_port_if: CPU bus pins, VRAM request channel and foreign-register strobe
//   CPU side   : CS_n, WR_n, RD_n, A, D -> D_out, BUSY_n; status_in from ControlUnit
//   VRAM side  : vram_req/we/addr/wdata -> vram_ack/vram_rdata
//   Reg strobe : reg_wr, reg_idx, reg_msb, reg_data
interface vdc_cpu_port_if;
    logic        CS_n;
    logic        WR_n;
    logic        RD_n;
    logic [1:0]  A;
    logic [7:0]  D;
    logic [7:0]  D_out;
    logic [5:0]  status_in;
    logic        BUSY_n;
    logic        vram_req;
    logic        vram_we;
    logic [15:0] vram_addr;
    logic [15:0] vram_wdata;
    logic        vram_ack;
    logic [15:0] vram_rdata;
    logic        reg_wr;
    logic [4:0]  reg_idx;
    logic        reg_msb;
    logic [7:0]  reg_data;
    modport slave (
        input  CS_n, WR_n, RD_n, A, D, status_in, vram_ack, vram_rdata,
        output D_out, BUSY_n, vram_req, vram_we, vram_addr, vram_wdata,
        output reg_wr, reg_idx, reg_msb, reg_data
    );
    modport master (
        output CS_n, WR_n, RD_n, A, D, status_in, vram_ack, vram_rdata,
        input  D_out, BUSY_n, vram_req, vram_we, vram_addr, vram_wdata,
        input  reg_wr, reg_idx, reg_msb, reg_data
    );
endinterface

// File: rtl/bus_edge_detect.sv
// bus_edge_detect: registers a bus strobe qualifier and emits a one-cycle event on its rising edge
//   clock, reset_n : clock and async active-low reset
//   i_q            : raw qualifier (e.g. ~CS_n & ~WR_n)
//   o_evt          : one-cycle pulse, the cycle after the qualifier is first sampled high
module bus_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic i_q,
    output logic o_evt
);
    logic r_q;
    logic r_q_d;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q   <= 1'b0;
            r_q_d <= 1'b0;
        end else begin
            r_q   <= i_q;
            r_q_d <= r_q;
        end
    end
    assign o_evt = r_q & ~r_q_d;
endmodule

// File: rtl/vdc_cpu_port.sv
// vdc_cpu_port: HuC6270 CPU register port - AR/MAWR/MARR/CR decode, VRAM write and read-prefetch sequencing
//   clock, reset_n : clock and async active-low reset
//   bus (slave)    : CPU pins, status_in, VRAM request channel and foreign-register strobe
module vdc_cpu_port
    import vdc_pkg::*;
(
    input  logic           clock,
    input  logic           reset_n,
    vdc_cpu_port_if.slave  bus
);
    logic        w_wr_evt;
    logic        w_rd_evt;
    logic        w_idle;
    logic        w_wr_ok;
    logic        w_msb;
    logic [15:0] w_inc;
    logic [4:0]  r_ar;
    logic [15:0] r_mawr;
    logic [15:0] r_marr;
    logic [1:0]  r_cr;
    logic [7:0]  r_wlo;
    logic [15:0] r_rbuf;
    logic [7:0]  r_dout;
    st_e         r_state;
    logic        r_busy_n;
    logic        r_req;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_reg_wr;
    logic [4:0]  r_reg_idx;
    logic        r_reg_msb;
    logic [7:0]  r_reg_data;

    bus_edge_detect u_wr_edge (.clock(clock), .reset_n(reset_n), .i_q(~bus.CS_n & ~bus.WR_n), .o_evt(w_wr_evt));
    bus_edge_detect u_rd_edge (.clock(clock), .reset_n(reset_n), .i_q(~bus.CS_n & ~bus.RD_n), .o_evt(w_rd_evt));

    assign w_idle  = (r_state == ST_IDLE);
    assign w_msb   = (bus.A == PORT_MSB);
    // data-port writes are dropped while a VRAM transaction is pending
    assign w_wr_ok = w_wr_evt & w_idle & ((bus.A == PORT_LSB) | w_msb);
    assign w_inc   = inc_of(r_cr);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ar       <= 5'd0;
            r_mawr     <= 16'd0;
            r_marr     <= 16'd0;
            r_cr       <= 2'b00;
            r_wlo      <= 8'd0;
            r_rbuf     <= 16'd0;
            r_dout     <= 8'd0;
            r_state    <= ST_IDLE;
            r_busy_n   <= 1'b1;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 16'd0;
            r_wdata    <= 16'd0;
            r_reg_wr   <= 1'b0;
            r_reg_idx  <= 5'd0;
            r_reg_msb  <= 1'b0;
            r_reg_data <= 8'd0;
        end else begin
            r_reg_wr <= 1'b0;
            if (w_wr_evt && bus.A == PORT_AR)
                r_ar <= bus.D[4:0];
            if (w_wr_ok) begin
                case (r_ar)
                    REG_MAWR: if (w_msb) r_mawr[15:8] <= bus.D; else r_mawr[7:0] <= bus.D;
                    REG_MARR: begin
                        if (w_msb) begin
                            // prefetch uses the freshly written MARR; increment lands on ack
                            r_marr[15:8] <= bus.D;
                            r_addr       <= {bus.D, r_marr[7:0]};
                            r_we         <= 1'b0;
                            r_req        <= 1'b1;
                            r_busy_n     <= 1'b0;
                            r_state      <= ST_RREQ;
                        end else
                            r_marr[7:0] <= bus.D;
                    end
                    REG_VRW: begin
                        if (w_msb) begin
                            r_addr   <= r_mawr;
                            r_wdata  <= {bus.D, r_wlo};
                            r_we     <= 1'b1;
                            r_req    <= 1'b1;
                            r_busy_n <= 1'b0;
                            r_state  <= ST_WREQ;
                        end else
                            r_wlo <= bus.D;
                    end
                    REG_CR: if (w_msb) r_cr <= bus.D[4:3];
                    default: begin
                        r_reg_wr   <= 1'b1;
                        r_reg_idx  <= r_ar;
                        r_reg_msb  <= w_msb;
                        r_reg_data <= bus.D;
                    end
                endcase
            end
            if (w_rd_evt) begin
                r_dout <= (bus.A == PORT_AR)  ? {1'b0, ~r_busy_n, bus.status_in} :
                          (bus.A == PORT_LSB) ? r_rbuf[7:0] :
                          (bus.A == PORT_MSB) ? r_rbuf[15:8] : 8'd0;
                if (w_msb && r_ar == REG_VRW && w_idle) begin
                    r_addr   <= r_marr;
                    r_we     <= 1'b0;
                    r_req    <= 1'b1;
                    r_busy_n <= 1'b0;
                    r_state  <= ST_RREQ;
                end
            end
            if (!w_idle && bus.vram_ack) begin
                r_req    <= 1'b0;
                r_busy_n <= 1'b1;
                r_state  <= ST_IDLE;
                if (r_state == ST_WREQ)
                    r_mawr <= r_mawr + w_inc;
                else begin
                    r_marr <= r_marr + w_inc;
                    r_rbuf <= bus.vram_rdata;
                end
            end
        end
    end

    assign bus.D_out      = r_dout;
    assign bus.BUSY_n     = r_busy_n;
    assign bus.vram_req   = r_req;
    assign bus.vram_we    = r_we;
    assign bus.vram_addr  = r_addr;
    assign bus.vram_wdata = r_wdata;
    assign bus.reg_wr     = r_reg_wr;
    assign bus.reg_idx    = r_reg_idx;
    assign bus.reg_msb    = r_reg_msb;
    assign bus.reg_data   = r_reg_data;
endmodule

// File: tb/tb_vdc_cpu_port.sv
// tb_vdc_cpu_port: directed self-checking bench for the VDC CPU register port
module tb_vdc_cpu_port;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   busy_total = 0;
    int   regwr_total = 0;
    logic [4:0] last_idx = '0;
    logic       last_msb = 1'b0;
    logic [7:0] last_data = '0;

    vdc_cpu_port_if bus ();
    vdc_cpu_port dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!bus.BUSY_n) busy_total <= busy_total + 1;
        if (bus.reg_wr) begin
            regwr_total <= regwr_total + 1;
            last_idx    <= bus.reg_idx;
            last_msb    <= bus.reg_msb;
            last_data   <= bus.reg_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clock);
        bus.CS_n = 1'b0; bus.WR_n = 1'b0; bus.A = a; bus.D = d;
        repeat (2) @(negedge clock);
        bus.CS_n = 1'b1; bus.WR_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [7:0] q);
        @(negedge clock);
        bus.CS_n = 1'b0; bus.RD_n = 1'b0; bus.A = a;
        repeat (2) @(negedge clock);
        bus.CS_n = 1'b1; bus.RD_n = 1'b1;
        q = bus.D_out;
    endtask

    task automatic txn(input string tag, input int dly, input logic [15:0] rdata,
                       input logic exp_we, input logic [15:0] exp_addr, input logic [15:0] exp_wdata);
        int n = 0;
        while (!bus.vram_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_req"}, 32'(bus.vram_req), 32'd1);
        if (bus.vram_req) begin
            check({tag, "_we"}, 32'(bus.vram_we), 32'(exp_we));
            check({tag, "_addr"}, 32'(bus.vram_addr), 32'(exp_addr));
            if (exp_we) check({tag, "_wdata"}, 32'(bus.vram_wdata), 32'(exp_wdata));
            repeat (dly) @(negedge clock);
            check({tag, "_hold"}, 32'({bus.vram_req, bus.vram_we, bus.vram_addr}), 32'({1'b1, exp_we, exp_addr}));
            bus.vram_ack = 1'b1; bus.vram_rdata = rdata;
            @(negedge clock);
            bus.vram_ack = 1'b0;
            check({tag, "_done"}, 32'({bus.vram_req, bus.BUSY_n}), 32'b01);
        end
    endtask

    initial begin
        logic [7:0] q;
        int b0;
        int r0;
        int rr;
        bus.CS_n = 1'b1; bus.WR_n = 1'b1; bus.RD_n = 1'b1; bus.A = 2'd0; bus.D = 8'd0;
        bus.status_in = 6'h15; bus.vram_ack = 1'b0; bus.vram_rdata = 16'd0;
        repeat (3) @(negedge clock);
        check("rst_busy_n", 32'(bus.BUSY_n), 32'd1);
        check("rst_req", 32'({bus.vram_req, bus.vram_we, bus.reg_wr}), 32'd0);
        check("rst_addr", 32'(bus.vram_addr), 32'd0);
        check("rst_wdata", 32'(bus.vram_wdata), 32'd0);
        check("rst_dout", 32'(bus.D_out), 32'd0);
        reset_n = 1'b1;
        rr = regwr_total;

        cpu_rd(2'd0, q);
        check("status_idle", 32'(q), 32'h15);

        cpu_wr(0, 8'h00); cpu_wr(2, 8'h34); cpu_wr(3, 8'h12);
        cpu_wr(0, 8'h02); cpu_wr(2, 8'hCD);
        b0 = busy_total;
        cpu_wr(3, 8'hAB);
        txn("w1", 3, 16'h0, 1'b1, 16'h1234, 16'hABCD);
        check("w1_busy_cycles", 32'(busy_total - b0), 32'd4);
        cpu_wr(2, 8'h11); cpu_wr(3, 8'h22);
        txn("w2", 0, 16'h0, 1'b1, 16'h1235, 16'h2211);

        cpu_wr(0, 8'h05); cpu_wr(3, 8'h18);
        cpu_wr(0, 8'h00); cpu_wr(2, 8'hC0); cpu_wr(3, 8'hFF);
        cpu_wr(0, 8'h02); cpu_wr(2, 8'h01); cpu_wr(3, 8'h02);
        txn("inc128", 1, 16'h0, 1'b1, 16'hFFC0, 16'h0201);
        cpu_wr(2, 8'h03); cpu_wr(3, 8'h04);
        txn("wrap", 0, 16'h0, 1'b1, 16'h0040, 16'h0403);
        cpu_wr(0, 8'h05); cpu_wr(3, 8'h00);

        cpu_wr(0, 8'h01); cpu_wr(2, 8'h00); cpu_wr(3, 8'h01);
        txn("pf0", 1, 16'h5A5A, 1'b0, 16'h0100, 16'h0);
        cpu_wr(0, 8'h02);
        cpu_rd(2'd2, q);
        check("vrr_lsb", 32'(q), 32'h5A);
        cpu_rd(2'd3, q);
        check("vrr_msb", 32'(q), 32'h5A);
        txn("pf1", 0, 16'h1234, 1'b0, 16'h0101, 16'h0);
        cpu_rd(2'd3, q);
        check("vrr_msb2", 32'(q), 32'h12);
        txn("pf2", 0, 16'hBEEF, 1'b0, 16'h0102, 16'h0);
        cpu_rd(2'd2, q);
        check("vrr_lsb2", 32'(q), 32'hEF);

        cpu_wr(2, 8'h55); cpu_wr(3, 8'h66);
        cpu_wr(2, 8'h77); cpu_wr(3, 8'h88);
        cpu_rd(2'd0, q);
        check("status_busy", 32'(q), 32'h55);
        txn("busy", 0, 16'h0, 1'b1, 16'h00C0, 16'h6655);
        repeat (3) @(negedge clock);
        check("drop_no_req", 32'(bus.vram_req), 32'd0);
        cpu_wr(2, 8'h01); cpu_wr(3, 8'h02);
        txn("after_drop", 0, 16'h0, 1'b1, 16'h00C1, 16'h0201);
        check("owned_no_regwr", 32'(regwr_total - rr), 32'd0);

        cpu_wr(0, 8'h07);
        r0 = regwr_total;
        @(negedge clock);
        bus.CS_n = 1'b0; bus.WR_n = 1'b0; bus.A = 2'd2; bus.D = 8'h3C;
        repeat (5) @(negedge clock);
        bus.CS_n = 1'b1; bus.WR_n = 1'b1;
        repeat (3) @(negedge clock);
        check("regwr_count", 32'(regwr_total - r0), 32'd1);
        check("regwr_fields", 32'({last_idx, last_msb, last_data}), 32'({5'h07, 1'b0, 8'h3C}));
        cpu_wr(3, 8'hA5);
        @(negedge clock);
        check("regwr_msb", 32'({last_idx, last_msb, last_data}), 32'({5'h07, 1'b1, 8'hA5}));

        cpu_wr(0, 8'h02); cpu_wr(2, 8'hAA); cpu_wr(3, 8'hBB);
        check("pre_rst_req", 32'(bus.vram_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst", 32'({bus.vram_req, bus.BUSY_n, bus.D_out}), 32'({1'b0, 1'b1, 8'h00}));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        cpu_wr(0, 8'h02); cpu_wr(3, 8'h22);
        txn("post_rst", 0, 16'h0, 1'b1, 16'h0000, 16'h2200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
